// File: rtl/md_issue_ctrl.sv
// Issue/sequencing control for the HI/LO multiply-divide unit of the 5-stage pipeline.
// Optional feature: define MDC_DIV0_SKIP_EN to skip div/divu whose divisor is zero.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_op,
  input  logic             e_rt_zero,
  input  logic             d_md_use,
  output logic             md_start,
  output logic [2:0]       md_sel,
  output logic             hi_en,
  output logic             lo_en,
  output logic             busy,
  output logic [CNT_W-1:0] remain,
  output logic             stall_d,
  output logic             op_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remain_nxt;

  logic start_class;
  logic is_div;
  logic div_skip;
  logic start_ok;

  assign start_class = e_valid && (e_op >= 4'd1) && (e_op <= 4'd6);
  assign is_div      = (e_op == 4'd3) || (e_op == 4'd4);

`ifdef MDC_DIV0_SKIP_EN
  // A zero divisor leaves HI/LO untouched, so the op is simply never started.
  assign div_skip = is_div && e_rt_zero;
`else
  logic unused_rt_zero;
  assign unused_rt_zero = e_rt_zero;
  assign div_skip = 1'b0;
`endif

  assign start_ok = start_class && !div_skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    case (state)
      IDLE: begin
        remain_nxt = '0;
        if (start_ok) begin
          state_nxt  = RUN;
          remain_nxt = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        // remain is always >= 1 here, so the decrement cannot wrap.
        if (remain <= CNT_W'(1)) begin
          state_nxt  = IDLE;
          remain_nxt = '0;
        end else begin
          remain_nxt = remain - CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        remain_nxt = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    md_start = 1'b0;
    md_sel   = 3'd0;
    hi_en    = 1'b0;
    lo_en    = 1'b0;
    op_err   = 1'b0;
    stall_d  = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        md_start = start_ok;
        hi_en    = e_valid && (e_op == 4'd7);
        lo_en    = e_valid && (e_op == 4'd8);
        if (start_ok) begin
          md_sel = e_op[2:0] - 3'd1;
        end
      end else begin
        op_err = start_class;
      end
      stall_d = d_md_use && (busy || md_start);
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-count reference model (honours MDC_DIV0_SKIP_EN).
module tb_md_issue_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDC_DIV0_SKIP_EN
  localparam bit SKIP_DIV0 = 1'b1;
`else
  localparam bit SKIP_DIV0 = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       e_valid;
  logic [3:0] e_op;
  logic       e_rt_zero;
  logic       d_md_use;
  logic       md_start;
  logic [2:0] md_sel;
  logic       hi_en;
  logic       lo_en;
  logic       busy;
  logic [4:0] remain;
  logic       stall_d;
  logic       op_err;

  int checks = 0;
  int errors = 0;
  int mdl_left = 0;

  md_issue_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_op     (e_op),
    .e_rt_zero(e_rt_zero),
    .d_md_use (d_md_use),
    .md_start (md_start),
    .md_sel   (md_sel),
    .hi_en    (hi_en),
    .lo_en    (lo_en),
    .busy     (busy),
    .remain   (remain),
    .stall_d  (stall_d),
    .op_err   (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drives one cycle of inputs, checks every output mid-cycle against the model, then advances.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic rtz,
                               input logic duse, input logic rst);
    bit is_start_op;
    bit is_div_op;
    bit exp_start;
    bit exp_busy;
    bit exp_hi;
    bit exp_lo;
    bit exp_err;
    bit exp_stall;
    int exp_sel;
    e_valid   = v;
    e_op      = op;
    e_rt_zero = rtz;
    d_md_use  = duse;
    reset     = rst;
    @(negedge clk);
    is_start_op = v && (op >= 1) && (op <= 6);
    is_div_op   = (op == 3) || (op == 4);
    exp_busy    = (mdl_left > 0);
    exp_start   = !rst && !exp_busy && is_start_op && !(SKIP_DIV0 && is_div_op && rtz);
    exp_sel     = exp_start ? int'(op) - 1 : 0;
    exp_hi      = !rst && !exp_busy && v && (op == 7);
    exp_lo      = !rst && !exp_busy && v && (op == 8);
    exp_err     = !rst && exp_busy && is_start_op;
    exp_stall   = !rst && duse && (exp_busy || exp_start);
    checkOutput("md_start", {7'd0, md_start}, {7'd0, exp_start});
    checkOutput("md_sel",   {5'd0, md_sel},   8'(exp_sel));
    checkOutput("hi_en",    {7'd0, hi_en},    {7'd0, exp_hi});
    checkOutput("lo_en",    {7'd0, lo_en},    {7'd0, exp_lo});
    checkOutput("busy",     {7'd0, busy},     {7'd0, exp_busy});
    checkOutput("remain",   {3'd0, remain},   8'(mdl_left));
    checkOutput("stall_d",  {7'd0, stall_d},  {7'd0, exp_stall});
    checkOutput("op_err",   {7'd0, op_err},   {7'd0, exp_err});
    if (rst) mdl_left = 0;
    else if (mdl_left > 0) mdl_left = mdl_left - 1;
    else if (exp_start) mdl_left = is_div_op ? DIV_N : MULT_N;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic duse);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, duse, 1'b0);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_op = 4'd0; e_rt_zero = 1'b0; d_md_use = 1'b0;
    @(posedge clk);
    #1;
    mdl_left = 0;

    // Reset held for two cycles, then released.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
    idleCycles(1, 1'b0);

    // mult: five busy cycles counting 5..1.
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    idleCycles(7, 1'b0);

    // div with a D-stage MD op waiting: stall spans T..T+10.
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    idleCycles(11, 1'b1);

    // mthi then mtlo in IDLE; also mfhi/mflo and out-of-range codes.
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Reset mid-multiply, then a div starts in the first cycle after reset.
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("div_after_reset_remain", {3'd0, remain}, 8'd10);
    idleCycles(10, 1'b0);

    // Divide by zero: skipped or run in full depending on the build.
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    idleCycles(11, 1'b0);

    // Op forced in while remain==3: suppressed, flagged, count undisturbed.
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    checkOutput("maddu_remain", {3'd0, remain}, 8'd5);
    idleCycles(5, 1'b0);

    // Random traffic, including occasional reset and stall violations.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
